// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier time-sharing scheduler.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam int CNT_W = 4;

  // A single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_any,
  output logic [ID_W-1:0] o_grant
);

  // Scan from farthest to nearest so the closest candidate to i_ptr wins.
  always_comb begin
    o_any   = |i_req;
    o_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_grant = ID_W'((int'(i_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one external combinational multiplier among NREQ requesters with
// round-robin arbitration, a settle window and a registered, id-tagged response.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("mult_share_sched: SETTLE_CYCLES must be in 1..15");
  end
  if (NREQ < 1 || NREQ > 16) begin : g_bad_nreq
    $error("mult_share_sched: NREQ must be in 1..16");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_rsp_valid;
  logic [2*WIDTH-1:0] r_rsp_p;
  logic [ID_W-1:0]    r_rsp_id;

  logic               w_any;
  logic [ID_W-1:0]    w_grant;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_grant (w_grant)
  );

  // Gated by rst so no accept pulse is advertised while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && r_state == IDLE && w_any) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ID_W'(i) == w_grant) req_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_p     <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a   <= req_a[int'(w_grant)*WIDTH +: WIDTH];
            r_op_b   <= req_b[int'(w_grant)*WIDTH +: WIDTH];
            r_rsp_id <= w_grant;
            r_rr_ptr <= (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;
            r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_p     <= mul_p;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);

endmodule
